// File: rtl/reservation_station_gen.sv
// Reservation station: captures dispatched micro-ops, snoops the CDB ports for wakeup and
// issues the oldest ready entry to one functional unit over a valid/ready handshake.
module reservation_station_gen #(
    parameter int unsigned RS_SIZE      = 8,
    parameter int unsigned RS_IDX_SIZE  = 3,
    parameter int unsigned NUM_CDB      = 2,
    parameter int unsigned GPR_SIZE     = 64,
    parameter int unsigned ROB_IDX_SIZE = 4,
    parameter int unsigned OP_W         = 5
) (
    input  logic                            in_clk,
    input  logic                            in_rst,
    input  logic                            in_flush,
    input  logic                            in_disp_valid,
    output logic                            out_disp_ready,
    input  logic [OP_W-1:0]                 in_disp_op,
    input  logic [ROB_IDX_SIZE-1:0]         in_disp_dst,
    input  logic                            in_disp_a_valid,
    input  logic                            in_disp_b_valid,
    input  logic [GPR_SIZE-1:0]             in_disp_a_value,
    input  logic [GPR_SIZE-1:0]             in_disp_b_value,
    input  logic [ROB_IDX_SIZE-1:0]         in_disp_a_tag,
    input  logic [ROB_IDX_SIZE-1:0]         in_disp_b_tag,
    input  logic                            in_disp_uses_nzcv,
    input  logic                            in_disp_nzcv_valid,
    input  logic                            in_disp_set_nzcv,
    input  logic [3:0]                      in_disp_nzcv,
    input  logic [ROB_IDX_SIZE-1:0]         in_disp_nzcv_tag,
    input  logic                            in_disp_is_load,
    input  logic [7:0]                      in_pending_stores,
    input  logic [NUM_CDB-1:0]              in_cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_SIZE-1:0] in_cdb_tag,
    input  logic [NUM_CDB*GPR_SIZE-1:0]     in_cdb_value,
    input  logic [NUM_CDB-1:0]              in_cdb_set_nzcv,
    input  logic [NUM_CDB*4-1:0]            in_cdb_nzcv,
    input  logic                            in_fu_ready,
    input  logic                            in_stall,
    output logic                            out_issue_valid,
    output logic [OP_W-1:0]                 out_issue_op,
    output logic [GPR_SIZE-1:0]             out_issue_a,
    output logic [GPR_SIZE-1:0]             out_issue_b,
    output logic [ROB_IDX_SIZE-1:0]         out_issue_dst,
    output logic [3:0]                      out_issue_nzcv,
    output logic                            out_issue_set_nzcv,
    output logic [RS_IDX_SIZE:0]            out_count
);
    localparam int unsigned CW = RS_IDX_SIZE + 1;

    logic [RS_SIZE-1:0]      r_valid;
    logic [RS_SIZE-1:0]      r_age [RS_SIZE];
    logic [OP_W-1:0]         r_op [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] r_dst [RS_SIZE];
    logic [RS_SIZE-1:0]      r_a_valid;
    logic [RS_SIZE-1:0]      r_b_valid;
    logic [RS_SIZE-1:0]      r_uses_nzcv;
    logic [RS_SIZE-1:0]      r_nzcv_valid;
    logic [RS_SIZE-1:0]      r_set_nzcv;
    logic [RS_SIZE-1:0]      r_is_load;
    logic [GPR_SIZE-1:0]     r_a_value [RS_SIZE];
    logic [GPR_SIZE-1:0]     r_b_value [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] r_a_tag [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] r_b_tag [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] r_nzcv_tag [RS_SIZE];
    logic [3:0]              r_nzcv [RS_SIZE];

    logic [ROB_IDX_SIZE-1:0] w_cdb_tag [NUM_CDB];
    logic [GPR_SIZE-1:0]     w_cdb_value [NUM_CDB];
    logic [3:0]              w_cdb_nzcv [NUM_CDB];

    logic [RS_SIZE-1:0]      w_wk_a;
    logic [RS_SIZE-1:0]      w_wk_b;
    logic [RS_SIZE-1:0]      w_wk_n;
    logic [GPR_SIZE-1:0]     w_wk_a_value [RS_SIZE];
    logic [GPR_SIZE-1:0]     w_wk_b_value [RS_SIZE];
    logic [3:0]              w_wk_nzcv [RS_SIZE];

    logic                    w_byp_a;
    logic                    w_byp_b;
    logic                    w_byp_n;
    logic [GPR_SIZE-1:0]     w_byp_a_value;
    logic [GPR_SIZE-1:0]     w_byp_b_value;
    logic [3:0]              w_byp_nzcv;

    logic                    w_st_block;
    logic [RS_SIZE-1:0]      w_ready;
    logic [RS_SIZE-1:0]      w_sel_oh;
    logic [RS_IDX_SIZE-1:0]  w_sel_idx;
    logic [RS_IDX_SIZE-1:0]  w_free_idx;
    logic [CW-1:0]           w_count;
    logic                    w_disp_fire;
    logic                    w_issue_fire;
    logic [RS_SIZE-1:0]      w_valid_nxt;
    logic [RS_SIZE-1:0]      w_age_nxt [RS_SIZE];

    always_comb begin
        for (int p = 0; p < NUM_CDB; p++) begin
            w_cdb_tag[p]   = in_cdb_tag[p*ROB_IDX_SIZE +: ROB_IDX_SIZE];
            w_cdb_value[p] = in_cdb_value[p*GPR_SIZE +: GPR_SIZE];
            w_cdb_nzcv[p]  = in_cdb_nzcv[p*4 +: 4];
        end
    end

    // Ports scanned high to low so the lowest matching port is the last to write.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_wk_a[i]       = 1'b0;
            w_wk_b[i]       = 1'b0;
            w_wk_n[i]       = 1'b0;
            w_wk_a_value[i] = '0;
            w_wk_b_value[i] = '0;
            w_wk_nzcv[i]    = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (in_cdb_valid[p] && w_cdb_tag[p] == r_a_tag[i]) begin
                    w_wk_a[i]       = 1'b1;
                    w_wk_a_value[i] = w_cdb_value[p];
                end
                if (in_cdb_valid[p] && w_cdb_tag[p] == r_b_tag[i]) begin
                    w_wk_b[i]       = 1'b1;
                    w_wk_b_value[i] = w_cdb_value[p];
                end
                if (in_cdb_valid[p] && in_cdb_set_nzcv[p] && w_cdb_tag[p] == r_nzcv_tag[i]) begin
                    w_wk_n[i]    = 1'b1;
                    w_wk_nzcv[i] = w_cdb_nzcv[p];
                end
            end
            w_wk_a[i] = w_wk_a[i] & r_valid[i] & ~r_a_valid[i];
            w_wk_b[i] = w_wk_b[i] & r_valid[i] & ~r_b_valid[i];
            w_wk_n[i] = w_wk_n[i] & r_valid[i] & r_uses_nzcv[i] & ~r_nzcv_valid[i];
        end
    end

    // Same-cycle broadcast captured straight into the entry being dispatched.
    always_comb begin
        w_byp_a       = 1'b0;
        w_byp_b       = 1'b0;
        w_byp_n       = 1'b0;
        w_byp_a_value = '0;
        w_byp_b_value = '0;
        w_byp_nzcv    = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (in_cdb_valid[p] && w_cdb_tag[p] == in_disp_a_tag) begin
                w_byp_a       = 1'b1;
                w_byp_a_value = w_cdb_value[p];
            end
            if (in_cdb_valid[p] && w_cdb_tag[p] == in_disp_b_tag) begin
                w_byp_b       = 1'b1;
                w_byp_b_value = w_cdb_value[p];
            end
            if (in_cdb_valid[p] && in_cdb_set_nzcv[p] && w_cdb_tag[p] == in_disp_nzcv_tag) begin
                w_byp_n    = 1'b1;
                w_byp_nzcv = w_cdb_nzcv[p];
            end
        end
        w_byp_a = w_byp_a & ~in_disp_a_valid;
        w_byp_b = w_byp_b & ~in_disp_b_valid;
        w_byp_n = w_byp_n & in_disp_uses_nzcv & ~in_disp_nzcv_valid;
    end

    assign w_st_block = |in_pending_stores;
    assign w_ready    = r_valid & r_a_valid & r_b_valid & (~r_uses_nzcv | r_nzcv_valid)
                      & ~(r_is_load & {RS_SIZE{w_st_block}});

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        w_sel_oh  = '0;
        w_sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            logic [RS_SIZE-1:0] w_self;
            w_self      = '0;
            w_self[i]   = 1'b1;
            w_sel_oh[i] = w_ready[i] & ~|(w_ready & ~r_age[i] & ~w_self);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_idx = RS_IDX_SIZE'(i);
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        w_count    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = RS_IDX_SIZE'(i);
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            w_count = w_count + CW'(r_valid[i]);
        end
    end

    assign out_count       = w_count;
    assign out_disp_ready  = (w_count < CW'(RS_SIZE));
    assign out_issue_valid = (|w_ready) & ~in_stall;
    assign w_disp_fire     = in_disp_valid & out_disp_ready;
    assign w_issue_fire    = out_issue_valid & in_fu_ready;

    always_comb begin
        out_issue_op       = '0;
        out_issue_a        = '0;
        out_issue_b        = '0;
        out_issue_dst      = '0;
        out_issue_nzcv     = '0;
        out_issue_set_nzcv = 1'b0;
        if (out_issue_valid) begin
            out_issue_op       = r_op[w_sel_idx];
            out_issue_a        = r_a_value[w_sel_idx];
            out_issue_b        = r_b_value[w_sel_idx];
            out_issue_dst      = r_dst[w_sel_idx];
            out_issue_nzcv     = r_nzcv[w_sel_idx];
            out_issue_set_nzcv = r_set_nzcv[w_sel_idx];
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_age_nxt[i] = r_age[i];
        end
        if (w_issue_fire) begin
            w_valid_nxt[w_sel_idx] = 1'b0;
            w_age_nxt[w_sel_idx]   = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                w_age_nxt[i][w_sel_idx] = 1'b0;
            end
        end
        if (w_disp_fire) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_valid_nxt[i]) begin
                    w_age_nxt[i][w_free_idx] = 1'b1;
                end
            end
            w_valid_nxt[w_free_idx] = 1'b1;
            w_age_nxt[w_free_idx]   = '0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_valid <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_age[i] <= '0;
            end
        end else if (in_flush) begin
            r_valid <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_disp_fire && w_free_idx == RS_IDX_SIZE'(i)) begin
                r_op[i]         <= in_disp_op;
                r_dst[i]        <= in_disp_dst;
                r_a_valid[i]    <= in_disp_a_valid | w_byp_a;
                r_a_value[i]    <= w_byp_a ? w_byp_a_value : in_disp_a_value;
                r_a_tag[i]      <= in_disp_a_tag;
                r_b_valid[i]    <= in_disp_b_valid | w_byp_b;
                r_b_value[i]    <= w_byp_b ? w_byp_b_value : in_disp_b_value;
                r_b_tag[i]      <= in_disp_b_tag;
                r_uses_nzcv[i]  <= in_disp_uses_nzcv;
                r_nzcv_valid[i] <= in_disp_nzcv_valid | w_byp_n;
                r_nzcv[i]       <= w_byp_n ? w_byp_nzcv : in_disp_nzcv;
                r_nzcv_tag[i]   <= in_disp_nzcv_tag;
                r_set_nzcv[i]   <= in_disp_set_nzcv;
                r_is_load[i]    <= in_disp_is_load;
            end else begin
                if (w_wk_a[i]) begin
                    r_a_valid[i] <= 1'b1;
                    r_a_value[i] <= w_wk_a_value[i];
                end
                if (w_wk_b[i]) begin
                    r_b_valid[i] <= 1'b1;
                    r_b_value[i] <= w_wk_b_value[i];
                end
                if (w_wk_n[i]) begin
                    r_nzcv_valid[i] <= 1'b1;
                    r_nzcv[i]       <= w_wk_nzcv[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_gen.sv
// Scoreboard bench: an in-order entry list predicts each cycle's offer, count and issued payload.
module tb_reservation_station_gen;
    localparam int RS = 8;
    localparam int NC = 2;
    localparam int W  = 64;
    localparam int TW = 4;
    localparam int OW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush, disp_valid, disp_ready;
    logic [OW-1:0] d_op;
    logic [TW-1:0] d_dst, d_at, d_bt, d_nt;
    logic d_av, d_bv, d_uses, d_nzv, d_set, d_ld;
    logic [W-1:0] d_a, d_b;
    logic [3:0] d_nz;
    logic [7:0] pend;
    logic [NC-1:0] cv, cset;
    logic [TW-1:0] ctag [NC];
    logic [W-1:0] cval [NC];
    logic [3:0] cnz [NC];
    logic [NC*TW-1:0] ctag_p;
    logic [NC*W-1:0] cval_p;
    logic [NC*4-1:0] cnz_p;
    logic fu_ready, stall;
    logic iv, iset;
    logic [OW-1:0] iop;
    logic [W-1:0] ia, ib;
    logic [TW-1:0] idst;
    logic [3:0] inz;
    logic [3:0] cnt;

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NC; p++) begin
            ctag_p[p*TW +: TW] = ctag[p];
            cval_p[p*W +: W]   = cval[p];
            cnz_p[p*4 +: 4]    = cnz[p];
        end
    end

    reservation_station_gen dut (
        .in_clk(clk), .in_rst(rst), .in_flush(flush),
        .in_disp_valid(disp_valid), .out_disp_ready(disp_ready),
        .in_disp_op(d_op), .in_disp_dst(d_dst),
        .in_disp_a_valid(d_av), .in_disp_b_valid(d_bv),
        .in_disp_a_value(d_a), .in_disp_b_value(d_b),
        .in_disp_a_tag(d_at), .in_disp_b_tag(d_bt),
        .in_disp_uses_nzcv(d_uses), .in_disp_nzcv_valid(d_nzv), .in_disp_set_nzcv(d_set),
        .in_disp_nzcv(d_nz), .in_disp_nzcv_tag(d_nt), .in_disp_is_load(d_ld),
        .in_pending_stores(pend),
        .in_cdb_valid(cv), .in_cdb_tag(ctag_p), .in_cdb_value(cval_p),
        .in_cdb_set_nzcv(cset), .in_cdb_nzcv(cnz_p),
        .in_fu_ready(fu_ready), .in_stall(stall),
        .out_issue_valid(iv), .out_issue_op(iop), .out_issue_a(ia), .out_issue_b(ib),
        .out_issue_dst(idst), .out_issue_nzcv(inz), .out_issue_set_nzcv(iset),
        .out_count(cnt)
    );

    typedef struct {
        logic [OW-1:0] op; logic [TW-1:0] dst;
        bit av; logic [W-1:0] a; logic [TW-1:0] at;
        bit bv; logic [W-1:0] b; logic [TW-1:0] bt;
        bit uses; bit nzv; logic [3:0] nz; logic [TW-1:0] nt; bit set; bit ld;
    } ent_t;
    typedef struct { bit v; logic [3:0] cnt; bit dr; } stat_t;
    typedef struct { logic [OW-1:0] op; logic [W-1:0] a; logic [W-1:0] b;
                     logic [TW-1:0] dst; logic [3:0] nz; bit set; } iss_t;

    ent_t  model[$];
    stat_t q_stat[$];
    iss_t  q_iss[$];
    stat_t m_s;
    iss_t  m_i;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rdy(input ent_t e);
        return e.av && e.bv && (!e.uses || e.nzv) && !(e.ld && pend != 8'd0);
    endfunction

    // Lowest port with a matching tag supplies an unresolved field.
    function automatic ent_t wake(input ent_t e);
        for (int p = 0; p < NC; p++) begin
            if (cv[p]) begin
                if (!e.av && ctag[p] == e.at) begin e.av = 1; e.a = cval[p]; end
                if (!e.bv && ctag[p] == e.bt) begin e.bv = 1; e.b = cval[p]; end
                if (e.uses && !e.nzv && cset[p] && ctag[p] == e.nt) begin
                    e.nzv = 1; e.nz = cnz[p];
                end
            end
        end
        return e;
    endfunction

    task automatic cycle();
        int k;
        bit fire, acc;
        stat_t s;
        iss_t is;
        ent_t e;
        k = -1;
        for (int i = 0; i < model.size(); i++) begin
            if (rdy(model[i])) begin k = i; break; end
        end
        s.v   = (k >= 0) && !stall;
        s.cnt = 4'(model.size());
        s.dr  = model.size() < RS;
        q_stat.push_back(s);
        fire = s.v && fu_ready;
        if (fire) begin
            is.op = model[k].op; is.a = model[k].a; is.b = model[k].b;
            is.dst = model[k].dst; is.nz = model[k].nz; is.set = model[k].set;
            q_iss.push_back(is);
        end
        acc = disp_valid && s.dr;
        @(posedge clk);
        if (flush) begin
            model.delete();
        end else begin
            if (fire) model.delete(k);
            foreach (model[i]) model[i] = wake(model[i]);
            if (acc) begin
                e.op = d_op; e.dst = d_dst; e.av = d_av; e.a = d_a; e.at = d_at;
                e.bv = d_bv; e.b = d_b; e.bt = d_bt; e.uses = d_uses; e.nzv = d_nzv;
                e.nz = d_nz; e.nt = d_nt; e.set = d_set; e.ld = d_ld;
                model.push_back(wake(e));
            end
        end
        #2;
    endtask

    always @(negedge clk) begin
        if (q_stat.size() > 0) begin
            m_s = q_stat.pop_front();
            chk("issue_valid", 64'(iv), 64'(m_s.v));
            chk("count", 64'(cnt), 64'(m_s.cnt));
            chk("disp_ready", 64'(disp_ready), 64'(m_s.dr));
            if (iv && fu_ready) begin
                if (q_iss.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL issue_unexpected: got dst %0h expected no issue", idst);
                end else begin
                    m_i = q_iss.pop_front();
                    chk("issue_op", 64'(iop), 64'(m_i.op));
                    chk("issue_a", ia, m_i.a);
                    chk("issue_b", ib, m_i.b);
                    chk("issue_dst", 64'(idst), 64'(m_i.dst));
                    chk("issue_nzcv", 64'(inz), 64'(m_i.nz));
                    chk("issue_set_nzcv", 64'(iset), 64'(m_i.set));
                end
            end
        end
    end

    task automatic idle();
        disp_valid = 0; flush = 0; stall = 0; pend = 8'd0;
        d_op = '0; d_dst = '0; d_av = 0; d_a = '0; d_at = '0; d_bv = 0; d_b = '0; d_bt = '0;
        d_uses = 0; d_nzv = 0; d_set = 0; d_nz = '0; d_nt = '0; d_ld = 0;
        cv = '0; cset = '0;
        for (int p = 0; p < NC; p++) begin ctag[p] = '0; cval[p] = '0; cnz[p] = '0; end
    endtask

    task automatic set_disp(input logic [OW-1:0] op, input logic [TW-1:0] dst, input bit av,
                            input logic [W-1:0] a, input logic [TW-1:0] at, input bit bv,
                            input logic [W-1:0] b, input bit ld);
        disp_valid = 1; d_op = op; d_dst = dst; d_av = av; d_a = a; d_at = at;
        d_bv = bv; d_b = b; d_bt = '0; d_uses = 0; d_nzv = 0; d_set = 0; d_nz = '0;
        d_nt = '0; d_ld = ld;
    endtask

    task automatic rand_in();
        disp_valid = $urandom_range(99) < 60;
        d_op = OW'($urandom); d_dst = TW'($urandom);
        d_av = $urandom_range(99) < 50; d_a = {$urandom, $urandom}; d_at = TW'($urandom_range(7));
        d_bv = $urandom_range(99) < 50; d_b = {$urandom, $urandom}; d_bt = TW'($urandom_range(7));
        d_uses = $urandom_range(99) < 50; d_nzv = $urandom_range(99) < 50;
        d_set = $urandom_range(99) < 50; d_nz = 4'($urandom); d_nt = TW'($urandom_range(7));
        d_ld = $urandom_range(99) < 25;
        pend = ($urandom_range(99) < 70) ? 8'd0 : 8'($urandom_range(3, 1));
        for (int p = 0; p < NC; p++) begin
            cv[p] = $urandom_range(99) < 50; cset[p] = $urandom_range(99) < 50;
            ctag[p] = TW'($urandom_range(7)); cval[p] = {$urandom, $urandom};
            cnz[p] = 4'($urandom);
        end
        fu_ready = $urandom_range(99) < 60;
        stall = $urandom_range(99) < 10;
        flush = $urandom_range(99) < 3;
    endtask

    initial begin
        idle();
        fu_ready = 0;
        #12;
        chk("reset_count", 64'(cnt), 64'd0);
        chk("reset_issue_valid", 64'(iv), 64'd0);
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_issue_a", ia, 64'd0);
        @(posedge clk); #2;
        rst = 0;

        // Resolved ADD issues one cycle after dispatch.
        fu_ready = 1;
        set_disp(5'd1, 4'd3, 1, 64'd5, '0, 1, 64'd7, 0); cycle();
        idle(); cycle(); cycle();

        // Two entries waiting on tag 9, woken together, issue oldest first.
        fu_ready = 0;
        set_disp(5'd2, 4'd1, 0, '0, 4'd9, 1, 64'd1, 0); cycle();
        set_disp(5'd2, 4'd2, 0, '0, 4'd9, 1, 64'd2, 0); cycle();
        idle(); cv[1] = 1; ctag[1] = 4'd9; cval[1] = 64'd42; cycle();
        idle(); fu_ready = 1; cycle(); cycle(); cycle();

        // Fill to capacity, drop the ninth, free one slot.
        fu_ready = 0;
        for (int i = 0; i < 9; i++) begin
            set_disp(5'd3, 4'(i), 1, 64'(i + 100), '0, 1, 64'(i), 0); cycle();
        end
        idle(); fu_ready = 1; cycle();
        fu_ready = 0; cycle();
        fu_ready = 1; repeat (9) cycle();

        // Dispatch-time bypass from port 0.
        idle(); fu_ready = 0;
        set_disp(5'd4, 4'd5, 0, '0, 4'd4, 1, 64'd1, 0);
        cv[0] = 1; ctag[0] = 4'd4; cval[0] = 64'hFF; cycle();
        idle(); fu_ready = 1; cycle(); cycle();

        // Load held back by older stores.
        idle(); fu_ready = 1;
        set_disp(5'd6, 4'd6, 1, 64'd11, '0, 1, 64'd12, 1); pend = 8'd2; cycle();
        idle(); pend = 8'd2; cycle(); cycle();
        pend = 8'd0; cycle(); cycle();

        // Flush beats a same-cycle dispatch.
        idle(); fu_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_disp(5'd7, 4'(i), 1, 64'(i), '0, 1, 64'(i), 0); cycle();
        end
        set_disp(5'd8, 4'd9, 1, 64'd1, '0, 1, 64'd1, 0); flush = 1; cycle();
        idle(); cycle(); fu_ready = 1; cycle();

        repeat (3000) begin
            rand_in();
            cycle();
        end
        idle(); fu_ready = 1; repeat (12) cycle();

        // Asynchronous reset mid-cycle with occupied entries.
        fu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_disp(5'd9, 4'(i), 1, 64'(i + 1), '0, 1, 64'(i), 0); cycle();
        end
        idle();
        #4;
        rst = 1;
        #1;
        chk("async_rst_count", 64'(cnt), 64'd0);
        chk("async_rst_issue_valid", 64'(iv), 64'd0);
        chk("async_rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("async_rst_issue_a", ia, 64'd0);
        model.delete();
        @(posedge clk); #2;
        rst = 0;
        fu_ready = 1; cycle(); cycle();

        @(negedge clk); #1;
        chk("leftover_issues", 64'(q_iss.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
